// File: rtl/spawn_rom_arbiter_pkg.sv
// Shared types and defaults for the spawn ROM arbiter.
package spawn_arb_pkg;

  localparam int DEF_ADDR_W      = 20;
  localparam int DEF_DATA_W      = 64;
  localparam int DEF_ROM_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_ATK = 1'b0,
    OWN_PLT = 1'b1
  } owner_t;

endpackage

// File: rtl/spawn_rom_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins; on a tie the side not
// granted last time wins. req/grant bit 0 = attack, bit 1 = platform.
module rr_arb2
  import spawn_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant from the request pair and the previous winner
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == OWN_PLT) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/spawn_rom_arbiter.sv
// Shares one ROM read port between the attack and platform requesters.
// One fetch in flight at a time; every output is registered.
// Optional grant statistics are enabled with macro SPAWN_ARB_STATS_EN.
module spawn_rom_arbiter
  import spawn_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ROM_LATENCY = DEF_ROM_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic              atk_req,
  input  logic [ADDR_W-1:0] atk_addr,
  output logic              atk_rsp_valid,
  output logic [DATA_W-1:0] atk_rsp_data,
  input  logic              plt_req,
  input  logic [ADDR_W-1:0] plt_addr,
  output logic              plt_rsp_valid,
  output logic [DATA_W-1:0] plt_rsp_data,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
`ifdef SPAWN_ARB_STATS_EN
  ,
  output logic [15:0]       atk_grant_cnt,
  output logic [15:0]       plt_grant_cnt
`endif
);

  localparam logic [2:0] LAT3 = 3'(ROM_LATENCY);

  state_t            state, state_next;
  owner_t            owner, owner_next;
  owner_t            last_grant, last_next;
  logic [2:0]        cnt, cnt_next;
  logic [1:0]        grant;
  logic              grant_fire;
  logic              rom_en_next, atk_valid_next, plt_valid_next;
  logic [ADDR_W-1:0] rom_addr_next;
  logic [DATA_W-1:0] atk_data_next, plt_data_next;

  rr_arb2 u_rr (
    .req   ({plt_req, atk_req}),
    .last  (last_grant),
    .grant (grant)
  );

  // Grants happen only from IDLE while not frozen
  assign grant_fire = (state == IDLE) && !freeze && (grant != 2'b00);

  // Next-state and next-output logic; cnt equals k in cycle N+k of a fetch
  always_comb begin
    state_next     = state;
    owner_next     = owner;
    last_next      = last_grant;
    cnt_next       = cnt;
    rom_en_next    = 1'b0;
    rom_addr_next  = rom_addr;
    atk_valid_next = 1'b0;
    plt_valid_next = 1'b0;
    atk_data_next  = atk_rsp_data;
    plt_data_next  = plt_rsp_data;
    case (state)
      IDLE: begin
        if (grant_fire) begin
          state_next    = WAIT;
          owner_next    = grant[1] ? OWN_PLT : OWN_ATK;
          last_next     = grant[1] ? OWN_PLT : OWN_ATK;
          cnt_next      = 3'd0;
          rom_en_next   = 1'b1;
          rom_addr_next = grant[1] ? plt_addr : atk_addr;
        end
      end
      WAIT: begin
        if (cnt == LAT3) begin
          state_next = RESP;
          if (owner == OWN_ATK) begin
            atk_valid_next = 1'b1;
            atk_data_next  = rom_data;
          end else begin
            plt_valid_next = 1'b1;
            plt_data_next  = rom_data;
          end
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= OWN_ATK;
      last_grant    <= OWN_PLT;
      cnt           <= 3'd0;
      rom_en        <= 1'b0;
      rom_addr      <= '0;
      atk_rsp_valid <= 1'b0;
      plt_rsp_valid <= 1'b0;
      atk_rsp_data  <= '0;
      plt_rsp_data  <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      owner         <= owner_next;
      last_grant    <= last_next;
      cnt           <= cnt_next;
      rom_en        <= rom_en_next;
      rom_addr      <= rom_addr_next;
      atk_rsp_valid <= atk_valid_next;
      plt_rsp_valid <= plt_valid_next;
      atk_rsp_data  <= atk_data_next;
      plt_rsp_data  <= plt_data_next;
      busy          <= (state_next != IDLE);
    end
  end

`ifdef SPAWN_ARB_STATS_EN
  // Saturating per-requester grant counters
  always_ff @(posedge clk) begin
    if (reset) begin
      atk_grant_cnt <= 16'd0;
      plt_grant_cnt <= 16'd0;
    end else if (grant_fire) begin
      if (grant[0] && atk_grant_cnt != 16'hFFFF) atk_grant_cnt <= atk_grant_cnt + 16'd1;
      if (grant[1] && plt_grant_cnt != 16'hFFFF) plt_grant_cnt <= plt_grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spawn_rom_arbiter.sv
// Directed bench for spawn_rom_arbiter: per-cycle vector table plus
// hand-written sequences for arbitration order, freeze and reset abort.
module tb_spawn_rom_arbiter;

  localparam int AW  = 20;
  localparam int DW  = 64;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset, freeze, atk_req, plt_req;
  logic [AW-1:0] atk_addr, plt_addr, rom_addr;
  logic          atk_rsp_valid, plt_rsp_valid, rom_en, busy;
  logic [DW-1:0] atk_rsp_data, plt_rsp_data, rom_data;
`ifdef SPAWN_ARB_STATS_EN
  logic [15:0]   atk_grant_cnt, plt_grant_cnt;
`endif

  int errors = 0;
  int checks = 0;

  spawn_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .atk_req(atk_req), .atk_addr(atk_addr),
    .atk_rsp_valid(atk_rsp_valid), .atk_rsp_data(atk_rsp_data),
    .plt_req(plt_req), .plt_addr(plt_addr),
    .plt_rsp_valid(plt_rsp_valid), .plt_rsp_data(plt_rsp_data),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy)
`ifdef SPAWN_ARB_STATS_EN
    , .atk_grant_cnt(atk_grant_cnt), .plt_grant_cnt(plt_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
    return {24'hC0FFEE, a, ~a};
  endfunction

  // ROM model: word valid only in cycle N+LAT, junk in every other cycle
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= rom_en ? romf(rom_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rom_data = pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          a, p, fz;
    logic [AW-1:0] aa, pa;
    logic          en;
    logic [AW-1:0] ea;
    logic          av, pv, bz;
    logic [DW-1:0] ad, pd;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic p, input logic fz,
                              input logic [AW-1:0] aa, input logic [AW-1:0] pa,
                              input logic en, input logic [AW-1:0] ea,
                              input logic av, input logic pv, input logic bz,
                              input logic [DW-1:0] ad, input logic [DW-1:0] pd);
    vec_t v;
    v.a = a; v.p = p; v.fz = fz; v.aa = aa; v.pa = pa; v.en = en; v.ea = ea;
    v.av = av; v.pv = pv; v.bz = bz; v.ad = ad; v.pd = pd;
    return v;
  endfunction

  vec_t vt [16];

  initial begin
    logic [DW-1:0] f10, f333, fp;
    logic [AW-1:0] g_addr [$];
    int            g_cyc [$];
    int            bad;

    f10  = romf(20'h00010);
    f333 = romf(20'h00333);
    fp   = romf(20'h2ABCD);

    // Each row: inputs applied for one cycle, expected outputs in the next
    vt[0]  = mk(1,0,0, 20'h00010,20'h2ABCD, 1,20'h00010, 0,0,1, 0,    0);
    vt[1]  = mk(1,0,0, 20'h00010,20'h2ABCD, 0,20'h0,     0,0,1, 0,    0);
    vt[2]  = mk(1,0,0, 20'h00010,20'h2ABCD, 0,20'h0,     0,0,1, 0,    0);
    vt[3]  = mk(1,0,0, 20'h00010,20'h2ABCD, 0,20'h0,     1,0,1, f10,  0);
    vt[4]  = mk(0,0,0, 20'h00010,20'h2ABCD, 0,20'h0,     0,0,0, f10,  0);
    vt[5]  = mk(0,1,0, 20'h00010,20'h2ABCD, 1,20'h2ABCD, 0,0,1, f10,  0);
    vt[6]  = mk(0,0,0, 20'h00010,20'h2ABCD, 0,20'h0,     0,0,1, f10,  0);
    vt[7]  = mk(0,0,0, 20'h00010,20'h2ABCD, 0,20'h0,     0,0,1, f10,  0);
    vt[8]  = mk(0,0,0, 20'h00010,20'h2ABCD, 0,20'h0,     0,1,1, f10,  fp);
    vt[9]  = mk(1,1,1, 20'h00333,20'h2ABCD, 0,20'h0,     0,0,0, f10,  fp);
    vt[10] = mk(1,1,0, 20'h00333,20'h2ABCD, 1,20'h00333, 0,0,1, f10,  fp);
    vt[11] = mk(1,1,1, 20'h00333,20'h2ABCD, 0,20'h0,     0,0,1, f10,  fp);
    vt[12] = mk(1,1,1, 20'h00333,20'h2ABCD, 0,20'h0,     0,0,1, f10,  fp);
    vt[13] = mk(1,1,1, 20'h00333,20'h2ABCD, 0,20'h0,     1,0,1, f333, fp);
    vt[14] = mk(0,1,1, 20'h00333,20'h2ABCD, 0,20'h0,     0,0,0, f333, fp);
    vt[15] = mk(0,1,0, 20'h00333,20'h2ABCD, 1,20'h2ABCD, 0,0,1, f333, fp);

    // Reset values
    reset = 1; freeze = 0; atk_req = 0; plt_req = 0; atk_addr = '0; plt_addr = '0;
    repeat (3) step();
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_atk_v", atk_rsp_valid, 0);
    chk("rst_plt_v", plt_rsp_valid, 0);
    chk("rst_atk_d", atk_rsp_data, 0);
    chk("rst_plt_d", plt_rsp_data, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
    step();

    // Vector table
    for (int i = 0; i < 16; i++) begin
      atk_req = vt[i].a; plt_req = vt[i].p; freeze = vt[i].fz;
      atk_addr = vt[i].aa; plt_addr = vt[i].pa;
      step();
      chk($sformatf("v%0d_rom_en", i), rom_en, vt[i].en);
      if (vt[i].en) chk($sformatf("v%0d_rom_addr", i), rom_addr, vt[i].ea);
      chk($sformatf("v%0d_atk_v", i), atk_rsp_valid, vt[i].av);
      chk($sformatf("v%0d_plt_v", i), plt_rsp_valid, vt[i].pv);
      chk($sformatf("v%0d_busy", i), busy, vt[i].bz);
      chk($sformatf("v%0d_atk_d", i), atk_rsp_data, vt[i].ad);
      chk($sformatf("v%0d_plt_d", i), plt_rsp_data, vt[i].pd);
    end

    // Tie right after reset, held for six transactions
    atk_req = 0; plt_req = 0; freeze = 0; reset = 1;
    step();
    reset = 0; atk_req = 1; plt_req = 1; atk_addr = 20'h00010; plt_addr = 20'h2ABCD;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (rom_en) begin
        g_addr.push_back(rom_addr);
        g_cyc.push_back(c);
      end
    end
    chk("rr_grant_count", g_addr.size(), 6);
    if (g_addr.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("rr_order%0d", k), g_addr[k], (k % 2 == 0) ? 20'h00010 : 20'h2ABCD);
        if (k > 0) chk($sformatf("rr_interval%0d", k), g_cyc[k] - g_cyc[k-1], LAT + 3);
      end
      chk("rr_first_cycle", g_cyc[0], 1);
    end

    // Freeze in IDLE blocks grants; release grants next cycle
    atk_req = 0; plt_req = 0; reset = 1;
    step();
    reset = 0; freeze = 1; atk_req = 1; plt_req = 1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (rom_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("freeze_hold_violations", bad, 0);
    freeze = 0;
    step();
    chk("freeze_release_rom_en", rom_en, 1);
    chk("freeze_release_addr", rom_addr, 20'h00010);

    // Reset in cycle N+1 aborts the fetch
    atk_req = 0; plt_req = 0; reset = 1;
    step();
    reset = 0; atk_req = 1; atk_addr = 20'h00444;
    step();
    chk("abort_N_rom_en", rom_en, 1);
    step();
    chk("abort_N1_busy", busy, 1);
    reset = 1; atk_req = 0;
    step();
    reset = 0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (atk_rsp_valid !== 1'b0 || plt_rsp_valid !== 1'b0 || busy !== 1'b0 ||
          rom_en !== 1'b0 || rom_addr !== '0 || atk_rsp_data !== '0 || plt_rsp_data !== '0)
        bad++;
      step();
    end
    chk("abort_outputs_violations", bad, 0);

`ifdef SPAWN_ARB_STATS_EN
    // Saturating grant statistics
    reset = 1;
    step();
    reset = 0;
    chk("stats_rst_atk", atk_grant_cnt, 0);
    chk("stats_rst_plt", plt_grant_cnt, 0);
    atk_req = 1; atk_addr = 20'h00010;
    for (int k = 0; k < 70000; k++) repeat (LAT + 3) step();
    atk_req = 0;
    repeat (LAT + 4) step();
    chk("stats_atk_sat", atk_grant_cnt, 16'hFFFF);
    chk("stats_plt_zero", plt_grant_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spawn_rom_arbiter.md
SPAWN_ROM_ARBITER -- requirements
Module: spawn_rom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 20, the ROM address width shared by both requesters.
REQ-002 The block SHALL have parameter DATA_W, default 64, the ROM record width.
REQ-003 The block SHALL have parameter ROM_LATENCY, default 2, the number of cycles from a rom_en cycle to valid rom_data; legal range 1..7.
REQ-004 The block SHALL have port clk  input  1  clock.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port freeze  input  1  inhibits new grants, used during a stage transition.
REQ-007 The block SHALL have port atk_req  input  1  attack requester fetch request, held high until the response.
REQ-008 The block SHALL have port atk_addr  input  ADDR_W  attack record address, stable while atk_req is high.
REQ-009 The block SHALL have port atk_rsp_valid  output  1  one-cycle attack response strobe.
REQ-010 The block SHALL have port atk_rsp_data  output  DATA_W  attack record, valid with atk_rsp_valid.
REQ-011 The block SHALL have ports plt_req, plt_addr, plt_rsp_valid and plt_rsp_data with the same directions, widths and meanings, for the platform requester.
REQ-012 The block SHALL have port rom_en  output  1  ROM read strobe.
REQ-013 The block SHALL have port rom_addr  output  ADDR_W  ROM read address.
REQ-014 The block SHALL have port rom_data  input  DATA_W  ROM read data.
REQ-015 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT and RESP, with all outputs registered.
REQ-017 In IDLE with freeze low and at least one request high, the block SHALL grant a requester and go to WAIT; in the next cycle (cycle N) rom_en=1 and rom_addr carries the granted address.
REQ-018 rom_en SHALL be high for exactly one cycle per grant.
REQ-019 When only one request is high, that requester SHALL be granted.
REQ-020 When both requests are high, the requester not granted last SHALL be granted (round-robin).
REQ-021 A grant SHALL update last_grant.
REQ-022 The block SHALL capture rom_data in cycle N+ROM_LATENCY and enter RESP.
REQ-023 In cycle N+ROM_LATENCY+1 the owner's rsp_valid SHALL be 1 and its rsp_data SHALL hold the captured record, with state RESP.
REQ-024 RESP SHALL last exactly one cycle with no arbitration, then return to IDLE.
REQ-025 The non-owner's rsp_valid SHALL stay 0 throughout a transaction.
REQ-026 rsp_data SHALL hold its value until the next response to the same requester.
REQ-027 A requester SHALL deassert req in the cycle it sees rsp_valid; a req still high in the next IDLE cycle SHALL be treated as a new fetch.
REQ-028 freeze high in IDLE SHALL block grants; freeze rising during WAIT or RESP SHALL NOT abort the transaction.
REQ-029 An owner dropping req mid-transaction SHALL NOT abort the transaction; the response SHALL still be strobed.
REQ-030 The latency counter SHALL be 3 bits and count up to ROM_LATENCY.
REQ-031 Back-to-back grant interval SHALL be ROM_LATENCY+3 cycles, from grant cycle to next grant cycle.

Reset
REQ-032 On reset the block SHALL set state=IDLE, rom_en=0, rom_addr=0, both rsp_valid=0, both rsp_data=0, busy=0, latency counter=0, last_grant=platform (attack wins the first tie).
REQ-033 Reset mid-transaction SHALL abort the transaction; no response SHALL be strobed for it afterwards.

Configuration
REQ-034 With macro SPAWN_ARB_STATS_EN defined, the block SHALL add outputs atk_grant_cnt and plt_grant_cnt, 16 bits each, which count grants, saturate at 0xFFFF and clear on reset.
REQ-035 Without SPAWN_ARB_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-036 Shared package spawn_arb_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the owner encoding (OWN_ATK=0, OWN_PLT=1) and the default widths and latency.
REQ-037 The two-way round-robin pick SHALL be a sub-module, rr_arb2: inputs req[1:0] and last; output grant one-hot; purely combinational.

Verification
REQ-038 The bench SHALL cover: atk_req=1, atk_addr=0x00010 alone, ROM_LATENCY=2 -> rom_en in cycle N, rom_addr=0x00010, atk_rsp_valid in N+3 with the ROM word, plt_rsp_valid stays 0.
REQ-039 The bench SHALL cover: both requests raised in the same cycle after reset -> attack granted first, platform next; grant interval 5 cycles.
REQ-040 The bench SHALL cover: both requests held continuously for 6 transactions -> grants alternate ATK, PLT, ATK, PLT, ATK, PLT.
REQ-041 The bench SHALL cover: freeze=1 with both requests high for 20 cycles -> rom_en stays 0 and busy stays 0; freeze falls -> grant in the next cycle.
REQ-042 The bench SHALL cover: reset asserted in cycle N+1 of a transaction -> no rsp_valid ever strobed, all outputs at reset values.
REQ-043 The bench SHALL cover, with SPAWN_ARB_STATS_EN defined: 70000 attack fetches -> atk_grant_cnt=0xFFFF and plt_grant_cnt=0.
